uart_transmitter: RTL and testbench

UART transmit path: accepts one parallel word per handshake, frames it as start bit, DATA_WIDTH data bits LSB-first, optional even/odd parity bit and one stop bit, and shifts it out one bit per clock. It is the sending end of the link whose far end is the oversampling UART receiver. It is clocked at the bit rate (the UART TX clock), so one clk period equals one bit time.

---
 rtl/uart_transmitter.sv | 131 +++++++++++++
 tb/tb_uart_transmitter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : uart_transmitter
// Description : UART transmit path clocked at the bit rate (one clk period is
//               one bit time). One parallel word is accepted per handshake in
//               IDLE. It is framed as:
//                 start bit, DATA_WIDTH data bits LSB first,
//                 optional even/odd parity bit, one stop bit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk             in   1           UART TX clock, one bit time per period
//   reset           in   1           asynchronous, active-high reset
//   parallel_data   in   DATA_WIDTH  word to send, sampled on acceptance
//   data_valid      in   1           send request, single-cycle or held
//   parity_enable   in   1           1 = append parity bit, sampled on acceptance
//   parity_type     in   1           0 = even, 1 = odd, sampled on acceptance
//   serial_data_out out  1           TX line, idles high, registered
//   busy            out  1           frame in flight, registered
//------------------------------------------------------------------------------
module uart_transmitter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] parallel_data,
  input  logic                  data_valid,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic                  serial_data_out,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  par_en;
  logic                  par_bit;

  // The line and busy are loaded together with the state register, so the
  // value driven during a cycle always belongs to the state held in that cycle.
  // The shift register's LSB is the data bit on the line during DATA. The shift
  // happens at the edge that moves on to the next bit, and that edge loads the
  // line from bit [1], which becomes the new LSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      shift_reg       <= '0;
      bit_cnt         <= '0;
      par_en          <= 1'b0;
      par_bit         <= 1'b0;
      serial_data_out <= 1'b1;
      busy            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_valid) begin
            shift_reg       <= parallel_data;
            par_en          <= parity_enable;
            // Even parity is the XOR of the word. Odd parity inverts it.
            par_bit         <= (^parallel_data) ^ parity_type;
            bit_cnt         <= '0;
            state           <= START;
            serial_data_out <= 1'b0;
            busy            <= 1'b1;
          end else begin
            serial_data_out <= 1'b1;
            busy            <= 1'b0;
          end
        end

        START: begin
          state           <= DATA;
          serial_data_out <= shift_reg[0];
          busy            <= 1'b1;
        end

        DATA: begin
          busy <= 1'b1;
          if (bit_cnt == LAST_BIT) begin
            if (par_en) begin
              state           <= PARITY;
              serial_data_out <= par_bit;
            end else begin
              state           <= STOP;
              serial_data_out <= 1'b1;
            end
          end else begin
            bit_cnt         <= bit_cnt + 1'b1;
            shift_reg       <= shift_reg >> 1;
            serial_data_out <= shift_reg[1];
          end
        end

        PARITY: begin
          state           <= STOP;
          serial_data_out <= 1'b1;
          busy            <= 1'b1;
        end

        STOP: begin
          // Requests are not accepted here. The earliest new acceptance is at
          // the following edge, in IDLE.
          state           <= IDLE;
          serial_data_out <= 1'b1;
          busy            <= 1'b0;
        end

        default: begin
          // Unused encodings fall back to an idle line.
          state           <= IDLE;
          serial_data_out <= 1'b1;
          busy            <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_uart_transmitter
// Description : Self-checking bench for uart_transmitter. A table of
//               hand-computed frames is applied, plus sequences for the idle
//               line, back-to-back requests and a mid-frame reset.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] parallel_data = 8'h00;
  logic       data_valid = 1'b0;
  logic       parity_enable = 1'b0;
  logic       parity_type = 1'b0;
  logic       serial_data_out;
  logic       busy;

  int checks = 0;
  int errors = 0;

  uart_transmitter #(.DATA_WIDTH(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .parallel_data   (parallel_data),
    .data_valid      (data_valid),
    .parity_enable   (parity_enable),
    .parity_type     (parity_type),
    .serial_data_out (serial_data_out),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Bit i of frame is the line value in cycle i of the frame (cycle 0 = start).
  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    int          len;
    logic [10:0] frame;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  // Issue one request, check every cycle of the frame, and scramble the
  // inputs (including spurious data_valid pulses) while the frame is in flight.
  task automatic send_frame(input vec_t v, input string tag);
    @(negedge clk);
    parallel_data = v.data;
    parity_enable = v.pe;
    parity_type   = v.pt;
    data_valid    = 1'b1;
    for (int i = 0; i < v.len; i++) begin
      @(negedge clk);
      check($sformatf("%s line[%0d]", tag, i), serial_data_out, v.frame[i]);
      check($sformatf("%s busy[%0d]", tag, i), busy, 1'b1);
      if (i == v.len - 1) begin
        data_valid = 1'b0;
      end else begin
        data_valid    = 1'($urandom_range(0, 1));
        parallel_data = 8'($urandom);
        parity_enable = 1'($urandom_range(0, 1));
        parity_type   = 1'($urandom_range(0, 1));
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("%s idle line[%0d]", tag, i), serial_data_out, 1'b1);
      check($sformatf("%s idle busy[%0d]", tag, i), busy, 1'b0);
    end
  endtask

  logic [20:0] b2b_line;
  logic [20:0] b2b_busy;

  initial begin
    // Parity values worked out by hand: A5 even->0, 01 odd->0, 00 odd->1,
    // 3C even->0, C3 odd->1, 80 even->1, 7E odd->1.
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 11, {1'b1, 1'b0, 8'hA5, 1'b0}};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 11, {1'b1, 1'b0, 8'h01, 1'b0}};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 11, {1'b1, 1'b1, 8'h00, 1'b0}};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 10, {1'b0, 1'b1, 8'hFF, 1'b0}};
    vecs[4] = '{8'h3C, 1'b1, 1'b0, 11, {1'b1, 1'b0, 8'h3C, 1'b0}};
    vecs[5] = '{8'hC3, 1'b1, 1'b1, 11, {1'b1, 1'b1, 8'hC3, 1'b0}};
    vecs[6] = '{8'h80, 1'b1, 1'b0, 11, {1'b1, 1'b1, 8'h80, 1'b0}};
    vecs[7] = '{8'h7E, 1'b1, 1'b1, 11, {1'b1, 1'b1, 8'h7E, 1'b0}};

    // Reset state and idle line.
    repeat (2) @(negedge clk);
    check("reset line", serial_data_out, 1'b1);
    check("reset busy", busy, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("idle line[%0d]", i), serial_data_out, 1'b1);
      check($sformatf("idle busy[%0d]", i), busy, 1'b0);
    end

    // Table-driven frames.
    for (int v = 0; v < 8; v++)
      send_frame(vecs[v], $sformatf("vec%0d", v));

    // Back-to-back with data_valid held: 3C then C3, no parity.
    // Stop of frame 1 in cycle 9, one idle cycle, start of frame 2 in cycle 11.
    b2b_line = {1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0};
    b2b_busy = {10'h3FF, 1'b0, 10'h3FF};
    @(negedge clk);
    parallel_data = 8'h3C;
    parity_enable = 1'b0;
    parity_type   = 1'b0;
    data_valid    = 1'b1;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      check($sformatf("b2b line[%0d]", i), serial_data_out, b2b_line[i]);
      check($sformatf("b2b busy[%0d]", i), busy, b2b_busy[i]);
      if (i == 0) parallel_data = 8'hC3;
      if (i == 11) data_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b end line", serial_data_out, 1'b1);
    check("b2b end busy", busy, 1'b0);

    // Reset during data bit 4 of 0x5A (frame cycle 5).
    @(negedge clk);
    parallel_data = 8'h5A;
    parity_enable = 1'b0;
    data_valid    = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      data_valid = 1'b0;
      check($sformatf("rst5A line[%0d]", i), serial_data_out, vecs_5a_bit(i));
      check($sformatf("rst5A busy[%0d]", i), busy, 1'b1);
    end
    reset = 1'b1;
    #1;
    check("async reset line", serial_data_out, 1'b1);
    check("async reset busy", busy, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("held reset line", serial_data_out, 1'b1);
      check("held reset busy", busy, 1'b0);
    end
    reset = 1'b0;
    send_frame('{8'h5A, 1'b0, 1'b0, 10, {1'b0, 1'b1, 8'h5A, 1'b0}}, "post-reset 5A");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Line value in cycle i of an unparitied 0x5A frame, hand-written.
  function automatic logic vecs_5a_bit(input int i);
    logic [9:0] f;
    f = {1'b1, 8'h5A, 1'b0};
    return f[i];
  endfunction

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
